// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM core pipeline control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: mem_state_t (memory wait FSM states), REG_IDX_W (register index
// width), DEF_MEM_WAIT / DEF_CNT_W defaults, and regHit() comparator helper.
package arm_pkg;

    localparam int REG_IDX_W    = 4;
    localparam int DEF_MEM_WAIT = 4;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // A source collides with a destination only if that destination
    // will actually be written back.
    function automatic logic regHit(
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dest,
        input logic                 wbEn
    );
        return wbEn && (src == dest);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-state inputs and stage-control outputs of pipe_ctrl.
// Latency: n/a (wiring only).
// Backpressure: n/a; freeze/id_en/pipe_en carry the stall to the stages.
//
// master: pipeline side (drives hazard/memory/branch status, consumes controls)
// slave : pipe_ctrl side (consumes status, drives controls and stall_count)
interface pipe_ctrl_if #(
    parameter int CNT_W = arm_pkg::DEF_CNT_W
);
    import arm_pkg::*;

    // ID-stage sources
    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
    logic                 Two_src;
    // Downstream destinations
    logic [REG_IDX_W-1:0] EXE_Dest;
    logic [REG_IDX_W-1:0] MEM_Dest;
    logic                 EXE_WB_EN;
    logic                 MEM_WB_EN;
    logic                 EXE_MEM_R_EN;
    // Memory access and branch status
    logic                 MEM_R_EN;
    logic                 MEM_W_EN;
    logic                 Branch_taken;
    // Stage controls
    logic                 freeze;
    logic                 flush;
    logic                 hazard;
    logic                 id_clr;
    logic                 id_en;
    logic                 pipe_en;
    logic                 mem_ready;
    logic [CNT_W-1:0]     stall_count;

    modport master (
        output src1, src2, Two_src, EXE_Dest, MEM_Dest, EXE_WB_EN, MEM_WB_EN,
               EXE_MEM_R_EN, MEM_R_EN, MEM_W_EN, Branch_taken,
        input  freeze, flush, hazard, id_clr, id_en, pipe_en, mem_ready,
               stall_count
    );

    modport slave (
        input  src1, src2, Two_src, EXE_Dest, MEM_Dest, EXE_WB_EN, MEM_WB_EN,
               EXE_MEM_R_EN, MEM_R_EN, MEM_W_EN, Branch_taken,
        output freeze, flush, hazard, id_clr, id_en, pipe_en, mem_ready,
               stall_count
    );

endinterface

// File: rtl/pipe_ctrl_mem_wait_fsm.sv
// Memory wait sequencer: holds the pipeline for MEM_WAIT cycles per access.
// Latency: memStall same cycle as memAccess in IDLE; memReady MEM_WAIT cycles later.
// Backpressure: new access accepted only in IDLE; memAccess drop in BUSY is ignored.
//
// Ports: clk, rst (sync active-low), memAccess in, memStall out (comb),
// memReady out (registered one-cycle pulse in DONE).
module mem_wait_fsm
    import arm_pkg::*;
#(
    parameter int MEM_WAIT = DEF_MEM_WAIT   // legal range 1..15
) (
    input  logic clk,
    input  logic rst,
    input  logic memAccess,
    output logic memStall,
    output logic memReady
);

    localparam logic [3:0] WAIT_M1 = 4'(MEM_WAIT - 1);

    mem_state_t state;
    logic [3:0] cnt;

    // The IDLE acceptance cycle already stalls, so BUSY covers the
    // remaining MEM_WAIT-1 cycles.
    assign memStall = (state == BUSY) || ((state == IDLE) && memAccess);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            memReady <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    memReady <= 1'b0;
                    if (memAccess) begin
                        cnt <= WAIT_M1;
                        if (MEM_WAIT == 1) begin
                            state    <= DONE;
                            memReady <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state    <= DONE;
                        memReady <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    memReady <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    memReady <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: freeze/flush/bubble/enable generation for the 5-stage core.
// Latency: all controls combinational (zero cycles); stall_count updates on the edge.
// Backpressure: memory wait > taken branch > RAW hazard > run.
//
// Ports: clk, rst (sync active-low), bus (pipe_ctrl_if.slave: ID sources,
// EXE/MEM destinations, memory and branch status in; freeze, flush, hazard,
// id_clr, id_en, pipe_en, mem_ready, stall_count out).
// Build option: define FORWARDING_EN when a forwarding unit is present; only
// load-use hazards against the EXE stage then stall.
module pipe_ctrl
    import arm_pkg::*;
#(
    parameter int MEM_WAIT = DEF_MEM_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    logic memStall;
    logic memReady;
    logic hazardRaw;
    logic exeHit;
    logic freezeC;
    logic flushC;
    logic idClrC;
    logic idEnC;
    logic pipeEnC;
    logic [CNT_W-1:0] stallCount;

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait (
        .clk       (clk),
        .rst       (rst),
        .memAccess (bus.MEM_R_EN | bus.MEM_W_EN),
        .memStall  (memStall),
        .memReady  (memReady)
    );

    // src2 only counts when the ID instruction actually reads it.
    assign exeHit = regHit(bus.src1, bus.EXE_Dest, bus.EXE_WB_EN)
                 || (bus.Two_src && regHit(bus.src2, bus.EXE_Dest, bus.EXE_WB_EN));

`ifdef FORWARDING_EN
    // Forwarding covers everything except a load result not yet read from memory.
    logic unusedMemFwd;
    assign unusedMemFwd = ^{bus.MEM_Dest, bus.MEM_WB_EN};
    assign hazardRaw    = exeHit && bus.EXE_MEM_R_EN;
`else
    logic memHit;
    assign memHit = regHit(bus.src1, bus.MEM_Dest, bus.MEM_WB_EN)
                 || (bus.Two_src && regHit(bus.src2, bus.MEM_Dest, bus.MEM_WB_EN));
    assign hazardRaw = exeHit || memHit;
`endif

    always_comb begin
        freezeC = 1'b0;
        flushC  = 1'b0;
        idClrC  = 1'b0;
        idEnC   = 1'b1;
        pipeEnC = 1'b1;
        if (memStall) begin
            // Whole pipe holds; a taken branch sitting in EXE stays there and
            // flushes once the access finishes.
            freezeC = 1'b1;
            idEnC   = 1'b0;
            pipeEnC = 1'b0;
        end else if (bus.Branch_taken) begin
            // No freeze: the PC must load the branch target this cycle.
            flushC = 1'b1;
            idClrC = 1'b1;
        end else if (hazardRaw) begin
            freezeC = 1'b1;
            idClrC  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCount <= '0;
        end else if (freezeC && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

    assign bus.freeze      = freezeC;
    assign bus.flush       = flushC;
    assign bus.hazard      = hazardRaw;
    assign bus.id_clr      = idClrC;
    assign bus.id_en       = idEnC;
    assign bus.pipe_en     = pipeEnC;
    assign bus.mem_ready   = memReady;
    assign bus.stall_count = stallCount;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MEM_WAIT=4, CNT_W=16); honours FORWARDING_EN.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: n/a.
module tb_pipe_ctrl;
    import arm_pkg::*;

`ifdef FORWARDING_EN
    localparam logic HZ_ALU = 1'b0;
    localparam logic HZ_MEM = 1'b0;
`else
    localparam logic HZ_ALU = 1'b1;
    localparam logic HZ_MEM = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    pipe_ctrl_if #(.CNT_W(16)) pc();

    pipe_ctrl #(
        .MEM_WAIT (4),
        .CNT_W    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (pc.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkCtrl(input string tag, input logic fz, input logic fl, input logic hz,
                           input logic clr, input logic ide, input logic pe, input logic mr);
        chk({tag, ".freeze"},    32'(pc.freeze),    32'(fz));
        chk({tag, ".flush"},     32'(pc.flush),     32'(fl));
        chk({tag, ".hazard"},    32'(pc.hazard),    32'(hz));
        chk({tag, ".id_clr"},    32'(pc.id_clr),    32'(clr));
        chk({tag, ".id_en"},     32'(pc.id_en),     32'(ide));
        chk({tag, ".pipe_en"},   32'(pc.pipe_en),   32'(pe));
        chk({tag, ".mem_ready"}, 32'(pc.mem_ready), 32'(mr));
    endtask

    task automatic idleIn();
        pc.src1 = '0; pc.src2 = '0; pc.Two_src = 1'b0;
        pc.EXE_Dest = '0; pc.MEM_Dest = '0;
        pc.EXE_WB_EN = 1'b0; pc.MEM_WB_EN = 1'b0; pc.EXE_MEM_R_EN = 1'b0;
        pc.MEM_R_EN = 1'b0; pc.MEM_W_EN = 1'b0; pc.Branch_taken = 1'b0;
    endtask

    initial begin
        // Reset for two edges, then release with idle inputs.
        rst = 1'b0;
        idleIn();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chkCtrl("reset", 0, 0, 0, 0, 1, 1, 0);
        chk("reset.stall_count", 32'(pc.stall_count), 32'd0);

        // Load at cycle 10; MEM_R_EN dropped after one cycle must not abort it.
        while (cyc < 10) tick();
        pc.MEM_R_EN = 1'b1;
        #1;
        chkCtrl("acc_c10", 1, 0, 0, 0, 0, 0, 0);
        tick();
        pc.MEM_R_EN = 1'b0;
        #1;
        chkCtrl("acc_c11", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 12; i <= 13; i++) begin
            tick();
            chk("acc_busy.freeze", 32'(pc.freeze), 32'd1);
            chk("acc_busy.mem_ready", 32'(pc.mem_ready), 32'd0);
        end
        tick();
        chkCtrl("acc_done_c14", 0, 0, 0, 0, 1, 1, 1);

        // Cycle 15: back in IDLE, a new store is accepted immediately.
        tick();
        pc.MEM_W_EN = 1'b1;
        #1;
        chk("acc2_c15.freeze", 32'(pc.freeze), 32'd1);
        chk("acc2_c15.mem_ready", 32'(pc.mem_ready), 32'd0);
        chk("acc2_c15.stall_count", 32'(pc.stall_count), 32'd4);

        // Taken branch during BUSY is held off until DONE.
        tick();
        pc.MEM_W_EN = 1'b0;
        pc.Branch_taken = 1'b1;
        #1;
        chkCtrl("br_busy_c16", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 17; i <= 18; i++) begin
            tick();
            chk("br_busy.flush", 32'(pc.flush), 32'd0);
            chk("br_busy.freeze", 32'(pc.freeze), 32'd1);
        end
        tick();
        chkCtrl("br_done_c19", 0, 1, 0, 1, 1, 1, 1);
        tick();
        pc.Branch_taken = 1'b0;
        #1;
        chkCtrl("idle_c20", 0, 0, 0, 0, 1, 1, 0);
        chk("idle_c20.stall_count", 32'(pc.stall_count), 32'd8);

        // ALU result dependency on src1 (forwardable).
        tick();
        pc.src1 = 4'd3; pc.EXE_Dest = 4'd3; pc.EXE_WB_EN = 1'b1;
        #1;
        chkCtrl("alu_dep", HZ_ALU, 0, HZ_ALU, HZ_ALU, 1, 1, 0);

        // Load-use: stalls in both builds.
        tick();
        pc.EXE_MEM_R_EN = 1'b1;
        #1;
        chkCtrl("load_use", 1, 0, 1, 1, 1, 1, 0);

        // src2 dependency on MEM stage with a taken branch: branch wins.
        tick();
        pc.EXE_WB_EN = 1'b0; pc.EXE_MEM_R_EN = 1'b0; pc.EXE_Dest = 4'd0;
        pc.src1 = 4'd1; pc.src2 = 4'd5; pc.Two_src = 1'b1;
        pc.MEM_Dest = 4'd5; pc.MEM_WB_EN = 1'b1; pc.Branch_taken = 1'b1;
        #1;
        chkCtrl("br_vs_hz", 0, 1, HZ_MEM, 1, 1, 1, 0);

        // Same dependency without the branch.
        tick();
        pc.Branch_taken = 1'b0;
        #1;
        chkCtrl("mem_dep", HZ_MEM, 0, HZ_MEM, HZ_MEM, 1, 1, 0);
        chk("mem_dep.stall_count", 32'(pc.stall_count), 32'(9 + int'(HZ_ALU)));

        // src2 not read by the instruction: no hazard.
        tick();
        pc.Two_src = 1'b0;
        #1;
        chkCtrl("no_two_src", 0, 0, 0, 0, 1, 1, 0);

        // Load-use through src2.
        tick();
        pc.Two_src = 1'b1; pc.EXE_Dest = 4'd5; pc.EXE_WB_EN = 1'b1;
        pc.EXE_MEM_R_EN = 1'b1; pc.MEM_WB_EN = 1'b0;
        #1;
        chkCtrl("load_use_src2", 1, 0, 1, 1, 1, 1, 0);

        tick();
        idleIn();
        #1;
        chkCtrl("idle_c27", 0, 0, 0, 0, 1, 1, 0);
        chk("idle_c27.stall_count", 32'(pc.stall_count),
            32'(10 + int'(HZ_ALU) + int'(HZ_MEM)));

        // Reset during BUSY aborts the access with no mem_ready pulse.
        tick();
        pc.MEM_W_EN = 1'b1;
        #1;
        chk("rst_acc.freeze", 32'(pc.freeze), 32'd1);
        tick();
        pc.MEM_W_EN = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_busy.freeze", 32'(pc.freeze), 32'd1);
        tick();
        #1;
        chkCtrl("rst_after", 0, 0, 0, 0, 1, 1, 0);
        chk("rst_after.stall_count", 32'(pc.stall_count), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_post.mem_ready", 32'(pc.mem_ready), 32'd0);
            chk("rst_post.freeze", 32'(pc.freeze), 32'd0);
        end

        // Hold a load-use stall for 70000 cycles: counter saturates.
        tick();
        pc.src1 = 4'd7; pc.EXE_Dest = 4'd7; pc.EXE_WB_EN = 1'b1; pc.EXE_MEM_R_EN = 1'b1;
        #1;
        chk("sat_start.freeze", 32'(pc.freeze), 32'd1);
        chk("sat_start.stall_count", 32'(pc.stall_count), 32'd0);
        repeat (65534) tick();
        chk("sat_m1.stall_count", 32'(pc.stall_count), 32'hFFFE);
        tick();
        chk("sat_full.stall_count", 32'(pc.stall_count), 32'hFFFF);
        repeat (70000 - 65535) tick();
        chk("sat_hold.stall_count", 32'(pc.stall_count), 32'hFFFF);
        chk("sat_hold.freeze", 32'(pc.freeze), 32'd1);
        idleIn();
        tick();
        chkCtrl("sat_end", 0, 0, 0, 0, 1, 1, 0);
        chk("sat_end.stall_count", 32'(pc.stall_count), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
